twos_to_sign_mag_serial: RTL and testbench
==========================================

Name: twos_to_sign_mag_serial

Overview:
- Bit-serial decoder: converts a WIDTH-bit two's-complement word into sign plus unsigned magnitude.
- Inverse of the team's combinational one's-complement-plus-one negator. Reuses the same invert-and-add-one arithmetic, one bit per clock, with a single carry flop.
- Sits between ALU result registers and the sign-magnitude display/serial output path.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 8, data width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- in_valid  input  1  A is valid this cycle.
- in_ready  output  1  block can accept A this cycle.
- A  input  WIDTH  two's-complement operand.
- out_valid  output  1  sign/magnitude/min_neg are valid.
- out_ready  input  1  consumer accepts result this cycle.
- sign  output  1  1 = negative operand.
- magnitude  output  WIDTH  unsigned |A|.
- min_neg  output  1  operand was the most negative value (only 1 followed by zeros).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low at clk edge):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - sign = 0, magnitude = 0, min_neg = 0, busy = 0.
  - Shift register, carry and bit counter cleared.
- Reset has priority over every other event, including mid-SHIFT or mid-DONE; any in-flight result is discarded with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0, busy = 0.
  - On in_valid & in_ready: latch A into the operand shift register and latch sign = A[WIDTH-1].
  - If sign = 1, or the macro is undefined: enter SHIFT with carry = 1 and count = 0.
  - Otherwise: enter DONE with magnitude = A.
- SHIFT:
  - in_ready = 0, busy = 1.
  - Each cycle processes operand bit i = count, LSB first.
  - For a negative operand: b = ~A[i] ^ carry; carry_next = ~A[i] & carry.
  - For a non-negative operand (only possible without the macro): b = A[i], and carry is ignored.
  - b is shifted into magnitude at the MSB; magnitude shifts right.
  - count increments; after the WIDTH-th bit (count == WIDTH-1), go to DONE.
  - Final carry is discarded (modulo 2^WIDTH).
- DONE:
  - out_valid = 1; sign, magnitude and min_neg are held stable until out_ready = 1.
  - On out_valid & out_ready: return to IDLE, with in_ready = 1 the next cycle.
  - No new input is accepted in the same cycle as the output handshake.
- min_neg:
  - Set in DONE when sign = 1 and magnitude = 2^(WIDTH-1). For WIDTH = 8, A = 0x80 gives magnitude 0x80, which fits unsigned, so the flag is informational.
  - 0 in all other cases.
- Latency from accept edge to out_valid high:
  - Negative operand: WIDTH + 1 cycles.
  - Non-negative operand: 1 cycle with the macro defined, WIDTH + 1 cycles without it.
- Throughput: one result per (latency + 1) cycles at best; no pipelining or overlap.
- A is sampled only on the accept cycle; later changes on A have no effect.
- out_ready held high continuously: DONE lasts exactly one cycle.
- in_valid while busy: ignored, no effect.

Optional Feature:
- Macro: TWOS_SM_FAST_POS_EN.
- Defined: non-negative operands bypass SHIFT; IDLE goes to DONE directly, latency 1.
- Undefined: every operand passes through SHIFT for WIDTH cycles, giving constant latency WIDTH + 1 regardless of sign. Non-negative bits are copied through unchanged (b = A[i]).
- Output values are identical in both builds.

Test Plan:
- Reset check: hold rst_n low 3 cycles, with an operand injected mid-SHIFT before reset is asserted.
  - Expect out_valid = 0, in_ready = 1, magnitude = 0, busy = 0 one edge after rst_n low.
  - The aborted operand never appears on the output.
- Negative operand: WIDTH = 8, A = 0xFB with out_ready = 1.
  - Expect sign = 1, magnitude = 0x05, min_neg = 0.
  - out_valid high exactly 9 cycles after accept, for 1 cycle.
- Positive operand: A = 0x05.
  - Macro defined: sign = 0, magnitude = 0x05, out_valid 1 cycle after accept.
  - Macro undefined: same values, 9 cycles after accept.
- Boundary values:
  - A = 0x80 → sign = 1, magnitude = 0x80, min_neg = 1.
  - A = 0xFF → sign = 1, magnitude = 0x01.
  - A = 0x00 → sign = 0, magnitude = 0x00.
  - A = 0x7F → sign = 0, magnitude = 0x7F.
- Backpressure: A = 0x9C with out_ready held low for 5 cycles in DONE.
  - Expect outputs stable at sign = 1, magnitude = 0x64 throughout.
  - in_ready = 0 throughout, and a second in_valid pulse is ignored.
  - Release out_ready: IDLE next cycle.
- Back-to-back: 0xFE then 0x03, each offered in the first cycle in_ready = 1.
  - Expect results (1, 0x02) then (0, 0x03), in order, with no lost or duplicated outputs.

Source files
------------

// File: rtl/twos_to_sign_mag_serial.sv
// Bit-serial two's-complement to sign/magnitude decoder.
// One operand bit per clock, LSB first, through invert-and-add-one with a
// single carry flop. Valid/ready handshake on both sides, one result in flight.
// Build option: define TWOS_SM_FAST_POS_EN to let non-negative operands skip
// the serial pass (latency 1 instead of WIDTH+1; results are identical).
module twos_to_sign_mag_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-1:0] magnitude,
  output logic             min_neg,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] mag;
  logic             sign_q;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_out;
  logic             last_bit;

  assign last_bit = (count == CW'(WIDTH - 1));
  // Negative operands run through invert-plus-one; non-negative bits pass as-is.
  assign bit_out  = sign_q ? (~opnd[0] ^ carry) : opnd[0];

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, WIDTH serial steps, hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef TWOS_SM_FAST_POS_EN
          state_nxt = A[WIDTH-1] ? SHIFT : DONE;
`else
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operand on accept, then shift one result bit in per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd   <= '0;
      mag    <= '0;
      sign_q <= 1'b0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd   <= A;
            sign_q <= A[WIDTH-1];
            carry  <= 1'b1;
            count  <= '0;
`ifdef TWOS_SM_FAST_POS_EN
            if (!A[WIDTH-1]) mag <= A;
`endif
          end
        end
        SHIFT: begin
          // Result enters at the MSB so after WIDTH steps bit 0 lands at bit 0.
          mag   <= {bit_out, mag[WIDTH-1:1]};
          opnd  <= opnd >> 1;
          carry <= ~opnd[0] & carry;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs decoded from state and held registers.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sign      = sign_q;
    magnitude = mag;
    min_neg   = (state == DONE) && sign_q &&
                (mag == {1'b1, {(WIDTH-1){1'b0}}});
  end

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Directed testbench for twos_to_sign_mag_serial (WIDTH = 8).
module tb_twos_to_sign_mag_serial;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic         out_valid;
  logic         out_ready;
  logic         sign;
  logic [W-1:0] magnitude;
  logic         min_neg;
  logic         busy;

  int checks = 0;
  int errors = 0;

  twos_to_sign_mag_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .magnitude (magnitude),
    .min_neg   (min_neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a);
`ifdef TWOS_SM_FAST_POS_EN
    return a[W-1] ? 9 : 1;
`else
    return 9;
`endif
  endfunction

  // Offer one operand as soon as in_ready is seen, wait for the result,
  // check values and latency, then confirm DONE lasts one cycle (out_ready=1).
  task automatic run_op(input logic [W-1:0] a, input logic es,
                        input logic [W-1:0] em, input logic en);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A        = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = ~a;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency",   32'(n),         32'(exp_lat(a)));
    check("out_valid", 32'(out_valid), 32'd1);
    check("sign",      32'(sign),      32'(es));
    check("magnitude", 32'(magnitude), 32'(em));
    check("min_neg",   32'(min_neg),   32'(en));
    check("busy_done", 32'(busy),      32'd1);
    @(negedge clk);
    check("done_1cyc", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-SHIFT discards the in-flight operand.
    in_valid = 1'b1;
    A        = 8'hFB;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_magnitude", 32'(magnitude), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_sign",      32'(sign),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("abort_no_output", 32'(n), 32'd0);

    // Main function and boundary values.
    run_op(8'hFB, 1'b1, 8'h05, 1'b0);
    run_op(8'h05, 1'b0, 8'h05, 1'b0);
    run_op(8'h80, 1'b1, 8'h80, 1'b1);
    run_op(8'hFF, 1'b1, 8'h01, 1'b0);
    run_op(8'h00, 1'b0, 8'h00, 1'b0);
    run_op(8'h7F, 1'b0, 8'h7F, 1'b0);

    // Backpressure: result held for 5 cycles, stray in_valid ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    A         = 8'h9C;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = 8'h00;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", 32'(n), 32'd9);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sign",      32'(sign),      32'd1);
      check("bp_magnitude", 32'(magnitude), 32'h64);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      if (i == 1) begin
        in_valid = 1'b1;
        A        = 8'h11;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_release_busy",  32'(busy),      32'd0);
    @(negedge clk);
    check("bp_stray_ignored", 32'(busy), 32'd0);

    // Back-to-back operands.
    run_op(8'hFE, 1'b1, 8'h02, 1'b0);
    run_op(8'h03, 1'b0, 8'h03, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
